// File: rtl/game_io_pkg.sv
// Shared types, constants and slot helpers for the game register controller.
package game_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int             NUM_SLOTS = 9;
  localparam int             SLOT_W    = 4;
  localparam logic [SLOT_W-1:0] SLOT_NONE = 4'd9;
  localparam int             TIMER_W   = 32;

  function automatic logic slot_valid(input logic [SLOT_W-1:0] slot);
    return (slot < SLOT_W'(NUM_SLOTS));
  endfunction

  // Any register value outside 0..8 (upper bits included) means "no target".
  function automatic logic [SLOT_W-1:0] decode_slot(input logic [31:0] reg_value);
    return (reg_value < 32'(NUM_SLOTS)) ? reg_value[SLOT_W-1:0] : SLOT_NONE;
  endfunction

  function automatic logic [SLOT_W-1:0] lowest_set(input logic [NUM_SLOTS-1:0] bits);
    logic [SLOT_W-1:0] result;
    result = SLOT_NONE;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (bits[k]) begin
        result = SLOT_W'(k);
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/game_io_ctrl_tracker.sv
// One target slot: remembers the last slot seen, runs its countdown and keeps the sticky hit flag.
module target_tracker
  import game_io_pkg::*;
#(
  parameter int TARGET_TICKS = 1500
) (
  input  logic               clock,
  input  logic               ctrl_reset_n,
  input  logic [SLOT_W-1:0]  slot_in,
  input  logic               tick,
  input  logic               run,
  input  logic               new_game,
  input  logic               game_end,
  input  logic               press_valid,
  input  logic [SLOT_W-1:0]  press_slot,
  output logic [TIMER_W-1:0] timer,
  output logic               hit
);

  logic [SLOT_W-1:0]  slot_r, slot_n;
  logic [TIMER_W-1:0] timer_r, timer_n;
  logic               hit_r, hit_n;

  // A slot change overrides both the tick and any coincident hit.
  always_comb begin
    slot_n  = slot_r;
    timer_n = timer_r;
    hit_n   = hit_r;
    if (slot_in != slot_r) begin
      slot_n  = slot_in;
      hit_n   = 1'b0;
      timer_n = slot_valid(slot_in) ? TIMER_W'(TARGET_TICKS) : {TIMER_W{1'b0}};
    end else begin
      if (game_end) begin
        timer_n = {TIMER_W{1'b0}};
      end else if (run && tick && (timer_r != {TIMER_W{1'b0}})) begin
        timer_n = timer_r - TIMER_W'(1);
      end else begin
        timer_n = timer_r;
      end
      if (new_game) begin
        hit_n = 1'b0;
      end else if (run && press_valid && slot_valid(slot_r) && (press_slot == slot_r)) begin
        hit_n = 1'b1;
      end else begin
        hit_n = hit_r;
      end
    end
  end

  // Tracker state register.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      slot_r  <= SLOT_NONE;
      timer_r <= {TIMER_W{1'b0}};
      hit_r   <= 1'b0;
    end else begin
      slot_r  <= slot_n;
      timer_r <= timer_n;
      hit_r   <= hit_n;
    end
  end

  assign timer = timer_r;
  assign hit   = hit_r;

endmodule

// File: rtl/game_io_ctrl.sv
// Game register controller: FSM, tick prescaler, game timer, button sync/edge detect and two target trackers.
module game_io_ctrl
  import game_io_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int GAME_TICKS   = 60000,
  parameter int TARGET_TICKS = 1500
) (
  input  logic                 clock,
  input  logic                 ctrl_reset_n,
  input  logic                 start,
  input  logic [NUM_SLOTS-1:0] buttons,
  input  logic [31:0]          t1active_read,
  input  logic [31:0]          t2active_read,
  output logic [31:0]          bp_write,
  output logic [31:0]          t1hit_write,
  output logic [31:0]          t2hit_write,
  output logic [31:0]          timer1_write,
  output logic [31:0]          timer2_write,
  output logic [31:0]          gametimer_write,
  output logic                 game_over
);

  state_t               state_r, state_n;
  logic [TIMER_W-1:0]   presc_r, gametimer_r;
  logic [NUM_SLOTS-1:0] sync1_r, sync2_r, prev_r, rise_r;
  logic                 bp_seen_r, game_over_r;
  logic [SLOT_W-1:0]    bp_slot_r;
  logic                 run_s, tick_s, game_end_s, new_game_s, press_valid_s;
  logic [SLOT_W-1:0]    press_slot_s;
  logic                 hit1_s, hit2_s;

  assign run_s         = (state_r == RUN);
  assign tick_s        = run_s && (presc_r == TIMER_W'(TICK_DIV - 1));
  assign game_end_s    = tick_s && (gametimer_r == TIMER_W'(1));
  assign press_valid_s = |rise_r;
  assign press_slot_s  = lowest_set(rise_r);

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_n    = state_r;
    new_game_s = 1'b0;
    case (state_r)
      IDLE, OVER: begin
        if (start) begin
          state_n    = RUN;
          new_game_s = 1'b1;
        end else begin
          state_n = state_r;
        end
      end
      RUN: begin
        if (game_end_s) begin
          state_n = OVER;
        end else begin
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, prescaler and game timer.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_r     <= IDLE;
      presc_r     <= {TIMER_W{1'b0}};
      gametimer_r <= {TIMER_W{1'b0}};
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      game_over_r <= (state_n == OVER);
      if (new_game_s) begin
        presc_r     <= {TIMER_W{1'b0}};
        gametimer_r <= TIMER_W'(GAME_TICKS);
      end else if (run_s) begin
        presc_r <= tick_s ? {TIMER_W{1'b0}} : presc_r + TIMER_W'(1);
        if (tick_s) begin
          gametimer_r <= gametimer_r - TIMER_W'(1);
        end
      end
    end
  end

  // Two-flop synchroniser, then a registered rising-edge detect (press visible three edges after the pin).
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      sync1_r <= {NUM_SLOTS{1'b0}};
      sync2_r <= {NUM_SLOTS{1'b0}};
      prev_r  <= {NUM_SLOTS{1'b0}};
      rise_r  <= {NUM_SLOTS{1'b0}};
    end else begin
      sync1_r <= buttons;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      rise_r  <= sync2_r & ~prev_r;
    end
  end

  // Last press register, reported in every state.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      bp_seen_r <= 1'b0;
      bp_slot_r <= {SLOT_W{1'b0}};
    end else if (press_valid_s) begin
      bp_seen_r <= 1'b1;
      bp_slot_r <= press_slot_s;
    end
  end

  target_tracker #(.TARGET_TICKS(TARGET_TICKS)) u_track1 (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .slot_in      (decode_slot(t1active_read)),
    .tick         (tick_s),
    .run          (run_s),
    .new_game     (new_game_s),
    .game_end     (game_end_s),
    .press_valid  (press_valid_s),
    .press_slot   (press_slot_s),
    .timer        (timer1_write),
    .hit          (hit1_s)
  );

  target_tracker #(.TARGET_TICKS(TARGET_TICKS)) u_track2 (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .slot_in      (decode_slot(t2active_read)),
    .tick         (tick_s),
    .run          (run_s),
    .new_game     (new_game_s),
    .game_end     (game_end_s),
    .press_valid  (press_valid_s),
    .press_slot   (press_slot_s),
    .timer        (timer2_write),
    .hit          (hit2_s)
  );

  assign bp_write        = {27'd0, bp_seen_r, bp_slot_r};
  assign t1hit_write     = {31'd0, hit1_s};
  assign t2hit_write     = {31'd0, hit2_s};
  assign gametimer_write = gametimer_r;
  assign game_over       = game_over_r;

endmodule
